// File: rtl/cpu_pkg.sv
// Shared CPU definitions: fetch-unit state encoding and default widths/addresses.
package cpu_pkg;

    localparam int unsigned ADDR_W_DEF     = 32;
    localparam int unsigned DATA_W_DEF     = 32;
    localparam logic [31:0] RESET_ADDR_DEF = 32'h0000_0000;
    localparam int unsigned PC_INC         = 4;

    typedef enum logic [2:0] {
        IDLE,
        FETCH,
        WAIT,
        HOLD,
        DRAIN
    } ifu_state_t;

endpackage

// File: rtl/ifetch_unit.sv
// Instruction fetch unit: one outstanding imem request, fetch PC ownership with
// redirect handling, and a registered valid/ready hand-off to decode.
module ifetch_unit
    import cpu_pkg::*;
#(
    parameter int unsigned ADDR_W     = ADDR_W_DEF,
    parameter int unsigned DATA_W     = DATA_W_DEF,
    parameter logic [ADDR_W-1:0] RESET_ADDR = ADDR_W'(RESET_ADDR_DEF)
) (
    input  logic              Clock,
    input  logic              Reset,
    input  logic              Redirect,
    input  logic [ADDR_W-1:0] Redirect_addr,
    output logic              Imem_req,
    output logic [ADDR_W-1:0] Imem_addr,
    input  logic              Imem_gnt,
    input  logic              Imem_rvalid,
    input  logic [DATA_W-1:0] Imem_rdata,
    output logic              Inst_valid,
    output logic [DATA_W-1:0] Inst_out,
    output logic [ADDR_W-1:0] Inst_pc,
    input  logic              Inst_ready
);

    ifu_state_t        state, state_n;
    logic [ADDR_W-1:0] fetch_pc, pc_n, redir_pc;
    logic              capture;

    // The request address is the fetch PC register itself, so it is registered by construction.
    assign Imem_addr = fetch_pc;
    assign redir_pc  = Redirect_addr & ~ADDR_W'(3);

    always_comb begin
        state_n = state;
        pc_n    = fetch_pc;
        capture = 1'b0;
        case (state)
            IDLE: begin
                state_n = FETCH;
                if (Redirect) pc_n = redir_pc;
            end
            FETCH: begin
                if (Redirect) pc_n = redir_pc;
                if (Imem_gnt) state_n = Redirect ? DRAIN : WAIT;
            end
            WAIT: begin
                if (Redirect) begin
                    pc_n    = redir_pc;
                    state_n = Imem_rvalid ? FETCH : DRAIN;
                end else if (Imem_rvalid) begin
                    capture = 1'b1;
                    pc_n    = fetch_pc + ADDR_W'(PC_INC);
                    state_n = HOLD;
                end
            end
            HOLD: begin
                if (Redirect) begin
                    pc_n    = redir_pc;
                    state_n = FETCH;
                end else if (Inst_ready) begin
                    state_n = FETCH;
                end
            end
            DRAIN: begin
                if (Redirect) pc_n = redir_pc;
                if (Imem_rvalid) state_n = FETCH;
            end
            default: state_n = IDLE;
        endcase
    end

    // Outputs are registered from the next state so req/valid line up with the state they describe.
    always_ff @(posedge Clock or negedge Reset) begin
        if (!Reset) begin
            state      <= IDLE;
            fetch_pc   <= RESET_ADDR;
            Imem_req   <= 1'b0;
            Inst_valid <= 1'b0;
            Inst_out   <= '0;
            Inst_pc    <= '0;
        end else begin
            state      <= state_n;
            fetch_pc   <= pc_n;
            Imem_req   <= (state_n == FETCH);
            Inst_valid <= (state_n == HOLD);
            if (capture) begin
                Inst_out <= Imem_rdata;
                Inst_pc  <= fetch_pc;
            end
        end
    end

endmodule

// File: tb/tb_ifetch_unit.sv
// Self-checking bench for ifetch_unit: table-driven fetches plus redirect/reset corner sequences.
module tb_ifetch_unit;
    import cpu_pkg::*;

    logic        Clock = 1'b0;
    logic        Reset = 1'b1;
    logic        Redirect = 1'b0;
    logic [31:0] Redirect_addr = '0;
    logic        Imem_req;
    logic [31:0] Imem_addr;
    logic        Imem_gnt = 1'b0;
    logic        Imem_rvalid = 1'b0;
    logic [31:0] Imem_rdata = '0;
    logic        Inst_valid;
    logic [31:0] Inst_out;
    logic [31:0] Inst_pc;
    logic        Inst_ready = 1'b0;

    ifetch_unit #(
        .ADDR_W    (32),
        .DATA_W    (32),
        .RESET_ADDR(32'h0000_0000)
    ) dut (
        .Clock        (Clock),
        .Reset        (Reset),
        .Redirect     (Redirect),
        .Redirect_addr(Redirect_addr),
        .Imem_req     (Imem_req),
        .Imem_addr    (Imem_addr),
        .Imem_gnt     (Imem_gnt),
        .Imem_rvalid  (Imem_rvalid),
        .Imem_rdata   (Imem_rdata),
        .Inst_valid   (Inst_valid),
        .Inst_out     (Inst_out),
        .Inst_pc      (Inst_pc),
        .Inst_ready   (Inst_ready)
    );

    always #5 Clock = ~Clock;

    typedef struct {
        logic [31:0] pc;
        logic [31:0] data;
    } exp_t;

    typedef struct {
        int unsigned gnt_dly;
        int unsigned rv_dly;
        int unsigned rdy_dly;
        logic [31:0] data;
    } vec_t;

    exp_t        sb[$];
    vec_t        vecs[5];
    logic [31:0] exp_pc;
    int          checks   = 0;
    int          failures = 0;

    task automatic tick();
        @(posedge Clock);
        #1;
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    task automatic wait_req();
        int unsigned n = 0;
        while (!Imem_req && n < 20) begin
            tick();
            n++;
        end
        chk("req_seen", 32'(Imem_req), 32'd1);
    endtask

    // Wait for a request, check its address, stall gnt for dly cycles, then grant.
    task automatic grant(input int unsigned dly);
        wait_req();
        chk("req_addr", Imem_addr, exp_pc);
        for (int unsigned i = 0; i < dly; i++) begin
            tick();
            chk("req_hold", 32'(Imem_req), 32'd1);
            chk("addr_hold", Imem_addr, exp_pc);
        end
        Imem_gnt = 1'b1;
        tick();
        Imem_gnt = 1'b0;
        chk("req_drop", 32'(Imem_req), 32'd0);
        chk("no_early_valid", 32'(Inst_valid), 32'd0);
    endtask

    task automatic deliver(input int unsigned rv_dly, input logic [31:0] data, input bit present);
        for (int unsigned i = 1; i < rv_dly; i++) tick();
        Imem_rvalid = 1'b1;
        Imem_rdata  = data;
        if (present) sb.push_back('{pc: exp_pc, data: data});
        tick();
        Imem_rvalid = 1'b0;
        Imem_rdata  = '0;
    endtask

    task automatic accept(input int unsigned rdy_dly);
        int unsigned n = 0;
        logic [31:0] out0, pc0;
        exp_t e;
        while (!Inst_valid && n < 10) begin
            tick();
            n++;
        end
        chk("valid_seen", 32'(Inst_valid), 32'd1);
        out0 = Inst_out;
        pc0  = Inst_pc;
        for (int unsigned i = 0; i < rdy_dly; i++) begin
            tick();
            chk("hold_valid", 32'(Inst_valid), 32'd1);
            chk("hold_out", Inst_out, out0);
            chk("hold_pc", Inst_pc, pc0);
            chk("hold_noreq", 32'(Imem_req), 32'd0);
        end
        Inst_ready = 1'b1;
        if (sb.size() == 0) begin
            chk("sb_nonempty", 32'd0, 32'd1);
        end else begin
            e = sb.pop_front();
            chk("inst_out", Inst_out, e.data);
            chk("inst_pc", Inst_pc, e.pc);
        end
        tick();
        Inst_ready = 1'b0;
        chk("valid_drop", 32'(Inst_valid), 32'd0);
        chk("refetch_req", 32'(Imem_req), 32'd1);
        exp_pc = exp_pc + 32'd4;
    endtask

    task automatic check_reset_outputs(input string tag);
        chk({tag, "_req"}, 32'(Imem_req), 32'd0);
        chk({tag, "_addr"}, Imem_addr, 32'h0000_0000);
        chk({tag, "_valid"}, 32'(Inst_valid), 32'd0);
        chk({tag, "_out"}, Inst_out, 32'd0);
        chk({tag, "_pc"}, Inst_pc, 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        vecs[0] = '{gnt_dly: 0, rv_dly: 1, rdy_dly: 0, data: 32'h2001_0005};
        vecs[1] = '{gnt_dly: 0, rv_dly: 1, rdy_dly: 5, data: 32'h1234_5678};
        vecs[2] = '{gnt_dly: 2, rv_dly: 3, rdy_dly: 1, data: 32'hA5A5_5A5A};
        vecs[3] = '{gnt_dly: 1, rv_dly: 2, rdy_dly: 0, data: 32'h0BAD_F00D};
        vecs[4] = '{gnt_dly: 3, rv_dly: 1, rdy_dly: 2, data: 32'hCAFE_0004};

        #2 Reset = 1'b0;
        #1 check_reset_outputs("reset");
        tick();
        tick();
        @(negedge Clock) Reset = 1'b1;
        exp_pc = 32'h0000_0000;

        foreach (vecs[i]) begin
            grant(vecs[i].gnt_dly);
            deliver(vecs[i].rv_dly, vecs[i].data, 1'b1);
            accept(vecs[i].rdy_dly);
        end

        // Redirect in WAIT, stale rvalid three cycles later must be dropped.
        grant(0);
        Redirect = 1'b1;
        Redirect_addr = 32'h0000_0103;
        tick();
        Redirect = 1'b0;
        chk("drain_noreq", 32'(Imem_req), 32'd0);
        tick();
        tick();
        deliver(1, 32'hDEAD_BEEF, 1'b0);
        chk("drain_novalid", 32'(Inst_valid), 32'd0);
        exp_pc = 32'h0000_0100;
        grant(0);
        deliver(1, 32'h1111_0100, 1'b1);
        accept(0);

        // Redirect coincident with rvalid in WAIT.
        grant(0);
        tick();
        Redirect = 1'b1;
        Redirect_addr = 32'h0000_2000;
        Imem_rvalid = 1'b1;
        Imem_rdata = 32'hBAD0_0001;
        tick();
        Redirect = 1'b0;
        Imem_rvalid = 1'b0;
        Imem_rdata = '0;
        chk("coinc_novalid", 32'(Inst_valid), 32'd0);
        exp_pc = 32'h0000_2000;
        grant(0);
        deliver(1, 32'h2222_2000, 1'b1);
        accept(0);

        // Redirect in HOLD with Inst_ready high drops the held word; then a slow grant.
        grant(0);
        deliver(1, 32'hBAD0_0002, 1'b0);
        chk("hold_entered", 32'(Inst_valid), 32'd1);
        Redirect = 1'b1;
        Redirect_addr = 32'h0000_3000;
        Inst_ready = 1'b1;
        tick();
        Redirect = 1'b0;
        Inst_ready = 1'b0;
        chk("hold_redir_novalid", 32'(Inst_valid), 32'd0);
        exp_pc = 32'h0000_3000;
        grant(4);
        deliver(2, 32'h3333_3000, 1'b1);
        accept(0);

        // Redirect in FETCH to the top word; PC wraps to zero afterwards.
        Redirect = 1'b1;
        Redirect_addr = 32'hFFFF_FFFF;
        tick();
        Redirect = 1'b0;
        exp_pc = 32'hFFFF_FFFC;
        grant(0);
        deliver(1, 32'h4444_FFFC, 1'b1);
        accept(0);
        chk("wrap_pc", exp_pc, 32'h0000_0000);

        // Reset during WAIT returns outputs immediately.
        grant(0);
        Reset = 1'b0;
        #1 check_reset_outputs("midreset");
        tick();
        @(negedge Clock) Reset = 1'b1;
        exp_pc = 32'h0000_0000;
        grant(0);
        deliver(1, 32'h5555_0000, 1'b1);
        accept(0);

        chk("sb_empty", 32'(sb.size()), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
